// File: rtl/oms_mult_sched.sv
// oms_mult_sched: round-robin scheduler sharing one OMS LUT multiplier between two requesters.
// Optional OMS_SCHED_CHECK_EN adds a sticky product self-check on chk_err.
module oms_mult_sched #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic [4:0] req_x0,
    input  logic [4:0] req_a0,
    input  logic [4:0] req_x1,
    input  logic [4:0] req_a1,
    output logic [1:0] req_ready,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [9:0] resp_data,
    output logic [4:0] mul_x,
    output logic [4:0] mul_a,
    output logic       mul_clear,
    input  logic [9:0] mul_result,
    output logic       chk_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);
    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic [1:0] grant;
    logic       accept, done;
    logic [4:0] op_x, op_a;
    // Contention goes to whoever was not granted last.
    assign grant[0] = req_valid[0] & (~req_valid[1] | last_grant);
    assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant);
    assign accept   = (state == IDLE) & |req_valid;
    assign done     = (state == ISSUE) & (cnt == 4'd0);
    assign mul_x    = op_x;
    assign mul_a    = op_a;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (accept)                               state_nxt = ISSUE;
        else if (done)                            state_nxt = RESP;
        else if (state == RESP && resp_ready)     state_nxt = IDLE;
    end
    always_comb begin
        req_ready  = (state == IDLE) ? grant : 2'b00;
        resp_valid = (state == RESP);
        mul_clear  = (state != ISSUE);
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            op_x       <= 5'd0;
            op_a       <= 5'd0;
            resp_id    <= 1'b0;
            resp_data  <= 10'd0;
        end else begin
            if (accept) begin
                op_x       <= grant[1] ? req_x1 : req_x0;
                op_a       <= grant[1] ? req_a1 : req_a0;
                resp_id    <= grant[1];
                last_grant <= grant[1];
                cnt        <= CNT_INIT;
            end else if (state == ISSUE) begin
                cnt <= cnt - 4'd1;
            end
            if (done) resp_data <= mul_result;
        end
`ifdef OMS_SCHED_CHECK_EN
    logic [9:0] ref_prod;
    assign ref_prod = 10'(op_x) * 10'(op_a);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) chk_err <= 1'b0;
        else          chk_err <= chk_err | (done & (mul_result != ref_prod));
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_oms_mult_sched.sv
// tb_oms_mult_sched: directed vectors, multi-cycle corner sequences and a randomized
// transaction-level model check for oms_mult_sched.
module tb_oms_mult_sched;
    localparam int S = 2;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [4:0] req_x0, req_a0, req_x1, req_a1;
    logic [1:0] req_ready;
    logic       resp_valid, resp_ready, resp_id;
    logic [9:0] resp_data;
    logic [4:0] mul_x, mul_a;
    logic       mul_clear;
    logic [9:0] mul_result;
    logic       chk_err;
    logic       force_en;
    logic [9:0] force_val;
    int checks = 0;
    int errors = 0;

    oms_mult_sched #(.SETTLE_CYC(S)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
        .req_x0(req_x0), .req_a0(req_a0), .req_x1(req_x1), .req_a1(req_a1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .mul_x(mul_x), .mul_a(mul_a),
        .mul_clear(mul_clear), .mul_result(mul_result), .chk_err(chk_err)
    );

    // Stand-in for the external multiplier, with an override to inject bad products.
    assign mul_result = force_en ? force_val : 10'(mul_x) * 10'(mul_a);

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [4:0] x;
        logic [4:0] a;
        logic [9:0] prod;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic [4:0] x, input logic [4:0] a);
        if (id) begin req_x1 = x; req_a1 = a; end
        else    begin req_x0 = x; req_a0 = a; end
        req_valid = id ? 2'b10 : 2'b01;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0; force_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic single_op(input logic id, input logic [4:0] x, input logic [4:0] a,
                             input logic [9:0] prod);
        @(negedge clk);
        drive_req(id, x, a);
        resp_ready = 1'b1;
        #1;
        chk("req_ready_idle", req_ready, id ? 2 : 1);
        chk("mul_clear_idle", mul_clear, 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("mul_clear_issue1", mul_clear, 0);
        chk("mul_x", mul_x, x);
        chk("mul_a", mul_a, a);
        chk("resp_valid_issue", resp_valid, 0);
        repeat (S - 1) @(negedge clk);
        chk("mul_clear_issue_last", mul_clear, 0);
        chk("resp_valid_issue_last", resp_valid, 0);
        @(negedge clk);
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, prod);
        chk("resp_id", resp_id, id);
        chk("mul_clear_resp", mul_clear, 1);
        @(negedge clk);
        chk("resp_valid_after", resp_valid, 0);
    endtask

    function automatic logic winner(input logic [1:0] v, input logic last);
        return (v == 2'b11) ? ~last : v[1];
    endfunction

    initial begin
        vec_t vecs[5];
        int   acc_cyc[$];
        logic acc_id[$];
        logic seen;
        vecs[0] = '{1'b0, 5'd7,  5'd5,  10'd35};
        vecs[1] = '{1'b1, 5'd31, 5'd31, 10'd961};
        vecs[2] = '{1'b0, 5'd19, 5'd0,  10'd0};
        vecs[3] = '{1'b1, 5'd16, 5'd1,  10'd16};
        vecs[4] = '{1'b0, 5'd3,  5'd9,  10'd27};
        req_x0 = 0; req_a0 = 0; req_x1 = 0; req_a1 = 0; force_val = 0;
        do_reset();
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_clear", mul_clear, 1);
        chk("rst_chk_err", chk_err, 0);
        chk("rst_req_ready", req_ready, 0);

        for (int i = 0; i < 5; i++) single_op(vecs[i].id, vecs[i].x, vecs[i].a, vecs[i].prod);

        // Reset in the first ISSUE cycle drops the operation.
        @(negedge clk);
        drive_req(1'b1, 5'd9, 5'd9);
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_mul_clear", mul_clear, 1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (S + 4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_reset", seen, 0);
        single_op(1'b0, 5'd7, 5'd5, 10'd35);

        // Contention from reset: alternate grants every S+2 cycles.
        do_reset();
        @(negedge clk);
        req_x0 = 5'd3; req_a0 = 5'd4; req_x1 = 5'd5; req_a1 = 5'd6;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                acc_cyc.push_back(c);
                acc_id.push_back(req_ready[1]);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("contention_accepts", acc_cyc.size(), 4);
        for (int k = 0; k < 4 && k < acc_cyc.size(); k++) begin
            chk("contention_cycle", acc_cyc[k], k * (S + 2));
            chk("contention_id", acc_id[k], k % 2);
        end
        repeat (S + 3) @(negedge clk);

        // Backpressure: response held, waiting requester not accepted.
        drive_req(1'b1, 5'd6, 5'd6);
        resp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 5'd2, 5'd3);
        repeat (S) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_data", resp_data, 36);
            chk("bp_resp_id", resp_id, 1);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_mul_clear", mul_clear, 1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_after", req_ready, 1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (S) @(negedge clk);
        chk("bp_next_valid", resp_valid, 1);
        chk("bp_next_data", resp_data, 6);
        chk("bp_next_id", resp_id, 0);
        @(negedge clk);

`ifdef OMS_SCHED_CHECK_EN
        do_reset();
        force_en = 1'b1;
        force_val = 10'd36;
        single_op(1'b0, 5'd7, 5'd5, 10'd36);
        chk("chk_err_set", chk_err, 1);
        force_en = 1'b0;
        single_op(1'b1, 5'd7, 5'd5, 10'd35);
        chk("chk_err_sticky", chk_err, 1);
        do_reset();
        chk("chk_err_cleared", chk_err, 0);
`endif

        // Randomized run against a transaction-level model.
        begin
            int         m_busy = 0;
            logic       m_pend = 0, m_last = 1, m_id = 0, w;
            logic [4:0] m_x = 0, m_a = 0;
            logic [1:0] acc = 0, exp_rdy;
            do_reset();
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                exp_rdy = (m_busy == 0 && !m_pend && req_valid != 0)
                          ? (winner(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00;
                chk("rnd_req_ready", req_ready, exp_rdy);
                chk("rnd_resp_valid", resp_valid, m_pend);
                if (m_pend) begin
                    chk("rnd_resp_id", resp_id, m_id);
                    chk("rnd_resp_data", resp_data, 10'(m_x) * 10'(m_a));
                end
                if (m_busy != 0) begin
                    chk("rnd_mul_clear", mul_clear, 0);
                    chk("rnd_mul_x", mul_x, m_x);
                    chk("rnd_mul_a", mul_a, m_a);
                end
                if (!(req_valid[0] && !acc[0])) begin
                    req_valid[0] = 1'($urandom_range(0, 1));
                    req_x0 = 5'($urandom); req_a0 = 5'($urandom);
                end
                if (!(req_valid[1] && !acc[1])) begin
                    req_valid[1] = 1'($urandom_range(0, 1));
                    req_x1 = 5'($urandom); req_a1 = 5'($urandom);
                end
                acc = 2'b00;
                resp_ready = ($urandom_range(0, 3) != 0);
                if (m_busy == 0 && !m_pend) begin
                    if (req_valid != 0) begin
                        w = winner(req_valid, m_last);
                        acc[w] = 1'b1;
                        m_last = w;
                        m_id = w;
                        m_x = w ? req_x1 : req_x0;
                        m_a = w ? req_a1 : req_a0;
                        m_busy = S;
                    end
                end else if (m_busy != 0) begin
                    m_busy--;
                    if (m_busy == 0) m_pend = 1'b1;
                end else if (resp_ready) begin
                    m_pend = 1'b0;
                end
            end
        end
`ifndef OMS_SCHED_CHECK_EN
        chk("chk_err_tied", chk_err, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oms_mult_sched.md
# oms_mult_sched

Single-port scheduler for the shared OMS LUT multiplier (`mem_mult_apc_oms`: 5-bit `x`, 5-bit `a`, `clear`, 10-bit `mult`).
- Arbitrates two requesters round-robin onto that one combinational multiplier.
- Holds operands stable for a programmable settle window and registers the product.
- Returns the product on a single valid/ready response channel tagged with the requester id.
- Sits between the requesting datapath blocks and the multiplier instance, which is instantiated outside this block.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles operands are held before the product is sampled. Legal range 1..15.

Ports:
- `clk`: input, 1 bit. Sole clock, rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `req_valid`: input, 2 bits. Per-requester request valid.
- `req_x0`, `req_a0`: input, 5 bits each. Requester 0 operands.
- `req_x1`, `req_a1`: input, 5 bits each. Requester 1 operands.
- `req_ready`: output, 2 bits. Per-requester accept.
- `resp_valid`: output, 1 bit. Product available.
- `resp_ready`: input, 1 bit. Consumer accepts the product.
- `resp_id`: output, 1 bit. Requester that owns the product.
- `resp_data`: output, 10 bits. Registered product.
- `mul_x`, `mul_a`: output, 5 bits each. Operands to the multiplier.
- `mul_clear`: output, 1 bit. 1 forces the multiplier decoder idle.
- `mul_result`: input, 10 bits. Multiplier `mult` output.
- `chk_err`: output, 1 bit. Sticky self-check error (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - `req_ready[i] = req_valid[i] & grant[i]`.
  - Grant rule: if exactly one `req_valid` bit is set, that requester is granted. If both are set, the requester not granted last is granted.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - On accept: latch the operands into `op_x`/`op_a`, latch `resp_id`, update `last_grant`, load `cnt = SETTLE_CYC-1`, go to ISSUE.
- ISSUE:
  - `mul_x = op_x`, `mul_a = op_a`, `mul_clear = 0`.
  - `cnt` decrements each cycle.
  - When `cnt == 0`: capture `resp_data <= mul_result` and go to RESP.
- RESP:
  - `resp_valid = 1`; `mul_clear = 1`; `mul_x`/`mul_a` hold their last values.
  - On `resp_valid & resp_ready`, go to IDLE.
  - `resp_data` and `resp_id` stay stable while `resp_valid & !resp_ready`.
- Operand latches `op_x`/`op_a` are held outside ISSUE.
- In IDLE, `mul_clear = 1`.
- Only one operation is outstanding at a time. No request is accepted outside IDLE.
- Arithmetic is unsigned 5x5 into 10 bits and cannot overflow; the block does not alter `mul_result`.
- Requests arriving outside IDLE wait; `req_valid` must stay high until `req_ready`.
- Reset at any point (including mid-ISSUE or mid-RESP): FSM goes to IDLE and the outstanding operation is dropped with no response.
- Reset values:
  - `resp_valid = 0`, `resp_data = 0`, `resp_id = 0`.
  - `mul_x = 0`, `mul_a = 0`, `mul_clear = 1`.
  - `chk_err = 0`, `last_grant = 1`.
  - `req_ready` combinational from IDLE; non-zero only if `req_valid` is set.

## Timing
- Accept edge at cycle 0.
- ISSUE occupies cycles 1..`SETTLE_CYC`.
- `mul_result` is sampled at the end of cycle `SETTLE_CYC`.
- `resp_valid` is high from cycle `SETTLE_CYC+1`.
- If `resp_ready` is held high, the response completes at the end of cycle `SETTLE_CYC+1` and IDLE is entered at cycle `SETTLE_CYC+2`.
- The next accept can occur in cycle `SETTLE_CYC+2`. Peak throughput is one product per `SETTLE_CYC+2` cycles.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Configuration
- `OMS_SCHED_CHECK_EN` defined:
  - At capture, `resp_data` is compared with `op_a*op_x` computed inside the block.
  - On mismatch, `chk_err` is set and stays set until reset. The response is still delivered.
- Not defined: the comparator is absent and `chk_err` is tied to 0.

## Test plan
- Single request, `SETTLE_CYC=2`: requester 0 sends `a=5`, `x=7` at cycle 0 -> `resp_valid` rises at cycle 3 with `resp_data=35`, `resp_id=0`; `mul_clear` is low only in cycles 1..2.
- Corner operands: `a=31`, `x=31` -> 961. `a=0`, `x=19` -> 0. `a=1`, `x=16` -> 16 (exercises `x[4]`).
- Contention: both requesters valid continuously with `resp_ready=1` -> grant order 0,1,0,1; each accept occurs every 4 cycles.
- Backpressure: `resp_ready` low for 5 cycles during RESP -> `resp_data`/`resp_id` stable, `req_ready` stays 0, and no new ISSUE starts.
- Reset mid-ISSUE: assert `reset_n=0` in cycle 1 -> `resp_valid=0`, `mul_clear=1` immediately; after release, no response is produced and a fresh request is served normally.
- With `OMS_SCHED_CHECK_EN`: force `mul_result` to 36 for `a=5`, `x=7` -> `chk_err=1` from the capture edge until reset, and `resp_data=36` is still delivered.
